// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with single-word refill.
// Hits return combinationally; misses stall the datapath until refilled.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        dp_imemREN,
    input  logic [31:0] dp_imemaddr,
    output logic        dp_ihit,
    output logic [31:0] dp_imemload,
    output logic        ram_iREN,
    output logic [31:0] ram_iaddr,
    input  logic        ram_iwait,
    input  logic [31:0] ram_iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    logic [0:0]    r_state;
    logic [SETS-1:0] r_valid;
    logic [TW-1:0] r_tag  [SETS];
    logic [31:0]   r_data [SETS];
    logic [31:0]   r_miss_addr;
    logic [31:0]   r_hit_cnt;
    logic [31:0]   r_miss_cnt;

    logic [IW-1:0] w_idx;
    logic [TW-1:0] w_tag;
    logic [IW-1:0] w_fidx;
    logic [TW-1:0] w_ftag;
    logic          w_idle;
    logic          w_hit;
    logic          w_miss;
    logic          w_fill;

    assign w_idx  = dp_imemaddr[IW+1:2];
    assign w_tag  = dp_imemaddr[31:IW+2];
    assign w_fidx = r_miss_addr[IW+1:2];
    assign w_ftag = r_miss_addr[31:IW+2];

    assign w_idle = (r_state == S_IDLE);
    assign w_hit  = w_idle & dp_imemREN & r_valid[w_idx]
                  & (r_tag[w_idx] == w_tag);
    assign w_miss = w_idle & dp_imemREN & ~w_hit;
    assign w_fill = (r_state == S_FETCH) & ~ram_iwait;

    assign dp_ihit     = w_hit;
    assign dp_imemload = w_hit ? r_data[w_idx] : 32'd0;
    assign ram_iREN    = (r_state == S_FETCH);
    assign ram_iaddr   = (r_state == S_FETCH) ? r_miss_addr : 32'd0;
    assign hit_count   = r_hit_cnt;
    assign miss_count  = r_miss_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_miss_addr <= 32'd0;
            r_hit_cnt   <= 32'd0;
            r_miss_cnt  <= 32'd0;
            for (int i = 0; i < SETS; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= 32'd0;
            end
        end else begin
            if (w_hit)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss) begin
                r_miss_addr <= {dp_imemaddr[31:2], 2'b00};
                r_miss_cnt  <= r_miss_cnt + 32'd1;
                r_state     <= S_FETCH;
            end
            if (w_fill) begin
                r_tag[w_fidx]  <= w_ftag;
                r_data[w_fidx] <= ram_iload;
                r_state        <= S_IDLE;
            end
            // Flush wins over a same-edge install: the line lands invalid.
            if (flush)
                r_valid <= '0;
            else if (w_fill)
                r_valid[w_fidx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed vector table, hand sequences
// and a randomized run against a word-address reference model.
module tb_icache;

    logic        CLK;
    logic        RST;
    logic        flush;
    logic        dp_imemREN;
    logic [31:0] dp_imemaddr;
    logic        dp_ihit;
    logic [31:0] dp_imemload;
    logic        ram_iREN;
    logic [31:0] ram_iaddr;
    logic        ram_iwait;
    logic [31:0] ram_iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks;
    int failures;

    icache #(.SETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .flush      (flush),
        .dp_imemREN (dp_imemREN),
        .dp_imemaddr(dp_imemaddr),
        .dp_ihit    (dp_ihit),
        .dp_imemload(dp_imemload),
        .ram_iREN   (ram_iREN),
        .ram_iaddr  (ram_iaddr),
        .ram_iwait  (ram_iwait),
        .ram_iload  (ram_iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        ren;
        logic [31:0] addr;
        logic        wt;
        logic [31:0] ld;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_rren;
        logic [31:0] e_raddr;
        logic [31:0] e_hc;
        logic [31:0] e_mc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic fl, input logic ren,
                       input logic [31:0] addr, input logic wt,
                       input logic [31:0] ld, input logic e_hit,
                       input logic [31:0] e_load, input logic e_rren,
                       input logic [31:0] e_raddr, input logic [31:0] e_hc,
                       input logic [31:0] e_mc);
        vec_t v;
        v.rst = 1'b0; v.fl = fl; v.ren = ren; v.addr = addr;
        v.wt = wt; v.ld = ld; v.e_hit = e_hit; v.e_load = e_load;
        v.e_rren = e_rren; v.e_raddr = e_raddr;
        v.e_hc = e_hc; v.e_mc = e_mc;
        tbl.push_back(v);
    endtask

    // Drive one cycle, compare outputs mid-cycle, advance past the edge.
    task automatic cyc(input vec_t v, input string tg);
        RST = v.rst; flush = v.fl; dp_imemREN = v.ren;
        dp_imemaddr = v.addr; ram_iwait = v.wt; ram_iload = v.ld;
        @(negedge CLK);
        chk({tg, ".ihit"}, {31'd0, dp_ihit}, {31'd0, v.e_hit});
        chk({tg, ".load"}, dp_imemload, v.e_load);
        chk({tg, ".rren"}, {31'd0, ram_iREN}, {31'd0, v.e_rren});
        chk({tg, ".raddr"}, ram_iaddr, v.e_raddr);
        chk({tg, ".hits"}, hit_count, v.e_hc);
        chk({tg, ".miss"}, miss_count, v.e_mc);
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic ren,
                                input logic [31:0] addr, input logic wt,
                                input logic e_hit, input logic [31:0] e_load,
                                input logic e_rren, input logic [31:0] e_raddr,
                                input logic [31:0] e_hc, input logic [31:0] e_mc);
        vec_t v;
        v.rst = rst; v.fl = 1'b0; v.ren = ren; v.addr = addr;
        v.wt = wt; v.ld = 32'h0; v.e_hit = e_hit; v.e_load = e_load;
        v.e_rren = e_rren; v.e_raddr = e_raddr;
        v.e_hc = e_hc; v.e_mc = e_mc;
        return v;
    endfunction

    // Reference model: lines keyed by word address, idle/busy refill.
    bit          m_v   [16];
    logic [29:0] m_wa  [16];
    logic [31:0] m_d   [16];
    bit          m_busy;
    logic [31:0] m_pend;
    logic [31:0] m_hc;
    logic [31:0] m_mc;

    function automatic logic [31:0] memval(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_v[i] = 1'b0; m_wa[i] = '0; m_d[i] = '0;
        end
        m_busy = 1'b0; m_pend = '0; m_hc = '0; m_mc = '0;
    endtask

    initial begin
        vec_t v;
        int ix;
        checks = 0;
        failures = 0;
        RST = 1'b1; flush = 1'b0; dp_imemREN = 1'b0;
        dp_imemaddr = '0; ram_iwait = 1'b0; ram_iload = '0;
        repeat (2) @(posedge CLK);
        #1;

        // Reset state
        cyc(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0), "reset");

        // Cold miss, warm hit
        add(0, 1, 32'h00, 1, 32'h0,         0, 0,            0, 32'h0,  0, 0);
        add(0, 1, 32'h00, 1, 32'h0,         0, 0,            1, 32'h0,  0, 1);
        add(0, 1, 32'h00, 1, 32'h0,         0, 0,            1, 32'h0,  0, 1);
        add(0, 1, 32'h00, 0, 32'h2001_0004, 0, 0,            1, 32'h0,  0, 1);
        add(0, 1, 32'h00, 1, 32'h0,         1, 32'h2001_0004, 0, 32'h0, 0, 1);
        add(0, 1, 32'h00, 1, 32'h0,         1, 32'h2001_0004, 0, 32'h0, 1, 1);
        add(0, 1, 32'h00, 1, 32'h0,         1, 32'h2001_0004, 0, 32'h0, 2, 1);
        add(0, 1, 32'h03, 1, 32'h0,         1, 32'h2001_0004, 0, 32'h0, 3, 1);
        add(0, 0, 32'h00, 1, 32'h0,         0, 0,            0, 32'h0,  4, 1);
        // Conflict on index 0
        add(0, 1, 32'h40, 0, 32'hAAAA_0001, 0, 0,            0, 32'h0,  4, 1);
        add(0, 1, 32'h40, 0, 32'hAAAA_0001, 0, 0,            1, 32'h40, 4, 2);
        add(0, 1, 32'h40, 1, 32'h0,         1, 32'hAAAA_0001, 0, 32'h0, 4, 2);
        add(0, 1, 32'h00, 1, 32'h0,         0, 0,            0, 32'h0,  5, 2);
        add(0, 1, 32'h00, 0, 32'h2001_0004, 0, 0,            1, 32'h0,  5, 3);
        add(0, 0, 32'h00, 1, 32'h0,         0, 0,            0, 32'h0,  5, 3);
        // Flush then re-miss
        add(1, 0, 32'h00, 1, 32'h0,         0, 0,            0, 32'h0,  5, 3);
        add(0, 1, 32'h00, 1, 32'h0,         0, 0,            0, 32'h0,  5, 3);
        // Flush coincident with refill completion
        add(1, 1, 32'h00, 0, 32'h1234_5678, 0, 0,            1, 32'h0,  5, 4);
        add(0, 1, 32'h00, 1, 32'h0,         0, 0,            0, 32'h0,  5, 4);
        add(0, 1, 32'h00, 0, 32'h1234_5678, 0, 0,            1, 32'h0,  5, 5);
        // Hit in flush cycle is still reported
        add(1, 1, 32'h00, 1, 32'h0,         1, 32'h1234_5678, 0, 32'h0, 5, 5);
        add(0, 1, 32'h00, 1, 32'h0,         0, 0,            0, 32'h0,  6, 5);
        add(0, 1, 32'h00, 0, 32'h5555_5555, 0, 0,            1, 32'h0,  6, 6);
        // Address change and REN drop during FETCH
        add(0, 1, 32'h08, 1, 32'h0,         0, 0,            0, 32'h0,  6, 6);
        add(0, 1, 32'h0C, 1, 32'h0,         0, 0,            1, 32'h8,  6, 7);
        add(0, 0, 32'h0C, 0, 32'hCAFE_0008, 0, 0,            1, 32'h8,  6, 7);
        add(0, 0, 32'h08, 1, 32'h0,         0, 0,            0, 32'h0,  6, 7);
        add(0, 1, 32'h08, 1, 32'h0,         1, 32'hCAFE_0008, 0, 32'h0, 6, 7);
        add(0, 1, 32'h0C, 1, 32'h0,         0, 0,            0, 32'h0,  7, 7);
        add(0, 0, 32'h0C, 0, 32'hBEEF_000C, 0, 0,            1, 32'hC,  7, 8);
        add(0, 1, 32'h0C, 1, 32'h0,         1, 32'hBEEF_000C, 0, 32'h0, 7, 8);

        for (int i = 0; i < tbl.size(); i++)
            cyc(tbl[i], $sformatf("vec%0d", i));

        // Reset mid-FETCH
        cyc(mk(0, 1, 32'h4, 1, 0, 0, 0, 0,   8, 8), "rst0");
        cyc(mk(1, 1, 32'h4, 1, 0, 0, 1, 32'h4, 8, 9), "rst1");
        cyc(mk(0, 0, 32'h4, 1, 0, 0, 0, 0,   0, 0), "rst2");
        cyc(mk(0, 1, 32'h4, 1, 0, 0, 0, 0,   0, 0), "rst3");
        cyc(mk(0, 1, 32'h4, 1, 0, 0, 1, 32'h4, 0, 1), "rst4");

        // Randomized run against the reference model
        RST = 1'b1; flush = 1'b0; dp_imemREN = 1'b0;
        @(posedge CLK);
        #1;
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        e_hit;
            logic [31:0] e_load;
            logic [29:0] wa;
            RST         = ($urandom_range(0, 199) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            dp_imemREN  = ($urandom_range(0, 3) != 0);
            dp_imemaddr = {26'd0, $urandom_range(0, 3) * 64
                                 + $urandom_range(0, 63)};
            if ($urandom_range(0, 9) == 0)
                dp_imemaddr = $urandom;
            ram_iwait   = ($urandom_range(0, 9) < 4);
            ram_iload   = m_busy ? memval(m_pend) : $urandom;
            wa = dp_imemaddr[31:2];
            ix = int'(wa % 16);
            e_hit  = !m_busy && dp_imemREN && m_v[ix] && (m_wa[ix] == wa);
            e_load = e_hit ? m_d[ix] : 32'd0;
            @(negedge CLK);
            chk("rnd.ihit", {31'd0, dp_ihit}, {31'd0, e_hit});
            chk("rnd.load", dp_imemload, e_load);
            chk("rnd.rren", {31'd0, ram_iREN}, {31'd0, m_busy});
            chk("rnd.raddr", ram_iaddr, m_busy ? m_pend : 32'd0);
            chk("rnd.hits", hit_count, m_hc);
            chk("rnd.miss", miss_count, m_mc);
            if (RST) begin
                m_reset();
            end else begin
                if (!m_busy) begin
                    if (e_hit) begin
                        m_hc = m_hc + 1;
                    end else if (dp_imemREN) begin
                        m_mc   = m_mc + 1;
                        m_busy = 1'b1;
                        m_pend = {wa, 2'b00};
                    end
                end else if (!ram_iwait) begin
                    ix = int'(m_pend[31:2] % 16);
                    m_v[ix]  = 1'b1;
                    m_wa[ix] = m_pend[31:2];
                    m_d[ix]  = ram_iload;
                    m_busy   = 1'b0;
                end
                if (flush)
                    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
            end
            @(posedge CLK);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the datapath's instruction-fetch port and the memory controller's instruction port. It returns hits combinationally in the request cycle. On a miss it runs a single-word refill from memory and stalls the datapath by holding `dp_ihit` low until the line is installed. It also keeps hit and miss counters for performance reporting.

## Interface
- `SETS`, default 16: number of one-word lines. Must be a power of two, at least 2. `IW = log2(SETS)`.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `flush` in 1: invalidate all lines at the next edge.
- `dp_imemREN` in 1: datapath instruction read request.
- `dp_imemaddr` in 32: fetch byte address. Bits [1:0] are ignored, index = [IW+1:2], tag = [31:IW+2].
- `dp_ihit` out 1: `dp_imemload` is valid this cycle.
- `dp_imemload` out 32: instruction word.
- `ram_iREN` out 1: memory read request.
- `ram_iaddr` out 32: memory read address, word-aligned.
- `ram_iwait` in 1: memory busy; data is not ready while high.
- `ram_iload` in 32: memory read data, valid when `ram_iREN`=1 and `ram_iwait`=0.
- `hit_count` out 32: accesses serviced as hits.
- `miss_count` out 32: misses taken.

## Operation
- **Storage:** per line a `valid` bit, a `(30-IW)`-bit tag and a 32-bit data word.
- **FSM** has two states, IDLE and FETCH.
- **IDLE:**
  - `hit` = `dp_imemREN` & `valid[idx]` & (`tag[idx]` == addr tag).
  - On `hit`: `dp_ihit`=1, `dp_imemload`=`data[idx]`, and `hit_count` increments.
  - On `dp_imemREN` & !`hit`: latch `{addr[31:2],2'b00}` into `miss_addr`, increment `miss_count`, go to FETCH.
  - With `dp_imemREN`=0: no state change, no counting.
- **FETCH:**
  - Drive `ram_iREN`=1 and `ram_iaddr`=`miss_addr`.
  - While `ram_iwait`=1, stay in FETCH.
  - When `ram_iwait`=0: write `ram_iload` and the tag of `miss_addr` into line `miss_addr[IW+1:2]`, set `valid`=1, go to IDLE.
  - `dp_ihit`=0 throughout FETCH.
- **Refill target:** refills always use `miss_addr`, never the live `dp_imemaddr`. Dropping `dp_imemREN` or changing the address during FETCH does not abort the refill. IDLE re-evaluates the current request on the next cycle.
- **Outputs in quiet conditions:** `dp_imemload`=0 whenever `dp_ihit`=0. `ram_iREN`=0 and `ram_iaddr`=0 in IDLE.
- **Flush:**
  - Clears every `valid` bit at the edge where `flush`=1, in either state.
  - If a refill completes at the same edge as `flush`, data and tag are written but `valid` stays 0.
  - Flush does not change FSM state or counters.
  - A hit in the flush cycle is still reported, because the cycle's lookup uses the pre-edge state.
- **Counters:** wrap modulo 2^32 and are not cleared by flush.
- **Eviction:** a conflicting tag on the same index overwrites the line; there is no write-back because the cache is read-only.

## Timing
- **Reset** (`RST`=1 at an edge) sets:
  - state IDLE;
  - all `valid`, tags, data and `miss_addr` to 0;
  - both counters to 0.
- **Outputs after reset:** `dp_ihit`=0, `dp_imemload`=0, `ram_iREN`=0, `ram_iaddr`=0.
- **Reset priority:** reset beats flush and refill completion. Reset during FETCH abandons the refill, and `ram_iREN` is 0 from the following cycle.
- **Hit latency:** 0 cycles; combinational in the request cycle.
- **Miss latency:** for memory holding `ram_iwait` high for W cycles, the hit appears at cycle 2+W relative to the miss-detect cycle 0:
  - cycle 0: detect;
  - cycles 1..1+W: FETCH, refill edge at the end of cycle 1+W;
  - cycle 2+W: IDLE hit.
- **Back-to-back misses:** each miss costs its own IDLE detect cycle. There is no miss-under-miss.
- **Combinational paths:** `dp_ihit` and `dp_imemload` depend combinationally on `dp_imemaddr`, `dp_imemREN` and the stored arrays only. `ram_iREN` and `ram_iaddr` are functions of state and registers only. There is no combinational path from `ram_*` inputs to `dp_*` outputs.

## Test plan
All scenarios use `SETS`=16.

- **Cold miss:** reset; REN addr 0x0000_0000; `ram_iwait`=1 for 2 cycles, then 0 with `ram_iload`=0x2001_0004.
  - Expect `ram_iREN`=1 and `ram_iaddr`=0x0 in cycles 1-3.
  - Expect `dp_ihit`=0 in cycles 0-3.
  - Expect `dp_ihit`=1 and `dp_imemload`=0x2001_0004 in cycle 4.
  - Expect `miss_count`=1 and `hit_count`=1 at the end of cycle 4.
- **Warm hit:** after scenario 1, REN 0x0000_0000 for 3 cycles.
  - Expect `dp_ihit`=1 each cycle, `ram_iREN`=0 throughout, and `hit_count` 1 → 4.
- **Conflict:** REN 0x0000_0040 (index 0, tag 1) with `ram_iload`=0xAAAA_0001.
  - Expect a miss and refill, then a hit returning 0xAAAA_0001.
  - Then REN 0x0 must miss again; `miss_count`=3.
- **Flush:** with line 0 valid, pulse `flush` for 1 cycle, then REN 0x0.
  - Expect a miss with `ram_iREN`=1 and unchanged counters except `miss_count`+1.
  - Flush coincident with refill completion: the next cycle misses again.
- **Reset mid-FETCH:** miss on 0x0000_0004, assert `RST` while `ram_iwait`=1.
  - Expect `ram_iREN`=0, `dp_ihit`=0 and counters 0 the next cycle.
  - A following REN 0x0000_0004 misses.
- **Address change during FETCH:** miss on 0x0000_0008, then change to 0x0000_000C and drop REN during FETCH.
  - Expect the refill to use 0x0000_0008 and index 2 to become valid.
  - Expect IDLE to report no hit while REN=0.
